// File: rtl/apb2axi_rd_txn_tracker_if.sv
// Bus bundle for the read transaction tracker: observed AR issue, the AXI R channel
// and the per-burst completion record. The master side drives stimulus, the slave side is the tracker.
interface apb2axi_rd_txn_tracker_if #(
  parameter int AXI_ID_W = 4,
  parameter int LEN_W    = 4
);
  logic                ar_fire;
  logic [AXI_ID_W-1:0] ar_id;
  logic [LEN_W-1:0]    ar_len;
  logic                rvalid;
  logic [AXI_ID_W-1:0] rid;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rready;
  logic                cmpl_valid;
  logic                cmpl_ready;
  logic [AXI_ID_W-1:0] cmpl_tag;
  logic [1:0]          cmpl_resp;
  logic                cmpl_len_err;

  modport master (
    output ar_fire, ar_id, ar_len, rvalid, rid, rresp, rlast, cmpl_ready,
    input  rready, cmpl_valid, cmpl_tag, cmpl_resp, cmpl_len_err
  );

  modport slave (
    input  ar_fire, ar_id, ar_len, rvalid, rid, rresp, rlast, cmpl_ready,
    output rready, cmpl_valid, cmpl_tag, cmpl_resp, cmpl_len_err
  );
endinterface

// File: rtl/apb2axi_rd_txn_tracker.sv
// Outstanding-read tracker: throttles request pops, tracks each AR by ID, counts and
// checks R beats, merges responses and emits one completion record per burst.
module apb2axi_rd_txn_tracker #(
  parameter int AXI_ID_W        = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int LEN_W           = 4,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  apb2axi_rd_txn_tracker_if.slave       bus,
  output logic                          pop_allow,
  output logic [CNT_W-1:0]              outstanding_cnt,
  output logic                          err_dup_id,
  output logic                          err_unexp_r
);

  localparam int                DEPTH     = 1 << AXI_ID_W;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [LEN_W:0]    BEAT_ONE  = (LEN_W + 1)'(1);

  logic             vld      [DEPTH];
  logic [LEN_W-1:0] exp_len  [DEPTH];
  logic [LEN_W:0]   beat_cnt [DEPTH];
  logic [1:0]       resp_acc [DEPTH];
  logic             len_err  [DEPTH];

  logic             r_fire;
  logic             r_hit;
  logic             r_done;
  logic             ar_ok;
  logic [LEN_W:0]   cur_beats;
  logic [LEN_W:0]   nxt_beats;
  logic [LEN_W:0]   exp_beats;
  logic [1:0]       nxt_resp;
  logic             nxt_len_err;

  assign bus.rready = !bus.cmpl_valid || bus.cmpl_ready;
  assign pop_allow  = outstanding_cnt < CNT_LIMIT;
  assign r_fire     = bus.rvalid && bus.rready;
  assign r_hit      = r_fire && vld[bus.rid];
  assign r_done     = r_hit && bus.rlast;
  // An AR on the ID completing this very cycle re-arms it instead of flagging a duplicate.
  assign ar_ok      = bus.ar_fire && (!vld[bus.ar_id] || (r_done && (bus.rid == bus.ar_id)));

  always_comb begin
    cur_beats   = beat_cnt[bus.rid];
    exp_beats   = (LEN_W + 1)'(exp_len[bus.rid]) + BEAT_ONE;
    nxt_beats   = cur_beats + BEAT_ONE;
    nxt_resp    = (bus.rresp > resp_acc[bus.rid]) ? bus.rresp : resp_acc[bus.rid];
    nxt_len_err = len_err[bus.rid] |
                  (bus.rlast ? (nxt_beats != exp_beats) : (cur_beats == exp_beats));
  end

  // Beat update first, then AR write, so a same-ID re-arm overrides the retired entry.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld[i]      <= 1'b0;
        exp_len[i]  <= '0;
        beat_cnt[i] <= '0;
        resp_acc[i] <= 2'b00;
        len_err[i]  <= 1'b0;
      end
    end else begin
      if (r_hit) begin
        beat_cnt[bus.rid] <= nxt_beats;
        resp_acc[bus.rid] <= nxt_resp;
        len_err[bus.rid]  <= nxt_len_err;
        if (bus.rlast)
          vld[bus.rid] <= 1'b0;
      end
      if (ar_ok) begin
        vld[bus.ar_id]      <= 1'b1;
        exp_len[bus.ar_id]  <= bus.ar_len;
        beat_cnt[bus.ar_id] <= '0;
        resp_acc[bus.ar_id] <= 2'b00;
        len_err[bus.ar_id]  <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      outstanding_cnt <= '0;
    end else if (ar_ok && !r_done) begin
      if (outstanding_cnt != CNT_MAX)
        outstanding_cnt <= outstanding_cnt + CNT_ONE;
    end else if (r_done && !ar_ok) begin
      if (outstanding_cnt != '0)
        outstanding_cnt <= outstanding_cnt - CNT_ONE;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      bus.cmpl_valid   <= 1'b0;
      bus.cmpl_tag     <= '0;
      bus.cmpl_resp    <= 2'b00;
      bus.cmpl_len_err <= 1'b0;
    end else if (r_done) begin
      bus.cmpl_valid   <= 1'b1;
      bus.cmpl_tag     <= bus.rid;
      bus.cmpl_resp    <= nxt_resp;
      bus.cmpl_len_err <= nxt_len_err;
    end else if (bus.cmpl_ready) begin
      bus.cmpl_valid   <= 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      err_dup_id  <= 1'b0;
      err_unexp_r <= 1'b0;
    end else begin
      err_dup_id  <= bus.ar_fire && !ar_ok;
      err_unexp_r <= r_fire && !vld[bus.rid];
    end
  end

endmodule

// File: tb/tb_apb2axi_rd_txn_tracker.sv
// Directed vector bench for apb2axi_rd_txn_tracker: one vector per clock, with the
// expected registered and combinational outputs sampled 1 ns after the rising edge.
module tb_apb2axi_rd_txn_tracker;

  logic       aclk;
  logic       aresetn;
  logic       pop_allow;
  logic [2:0] outstanding_cnt;
  logic       err_dup_id;
  logic       err_unexp_r;
  int         total;
  int         bad;

  apb2axi_rd_txn_tracker_if #(.AXI_ID_W(4), .LEN_W(4)) bus ();

  apb2axi_rd_txn_tracker #(
    .AXI_ID_W(4), .MAX_OUTSTANDING(4), .LEN_W(4)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .bus             (bus),
    .pop_allow       (pop_allow),
    .outstanding_cnt (outstanding_cnt),
    .err_dup_id      (err_dup_id),
    .err_unexp_r     (err_unexp_r)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    string      name;
    logic       rst_n;
    logic       ar_fire;
    logic [3:0] ar_id;
    logic [3:0] ar_len;
    logic       rvalid;
    logic [3:0] rid;
    logic [1:0] rresp;
    logic       rlast;
    logic       cmpl_ready;
    logic       pa;
    logic       rr;
    logic       cv;
    logic [3:0] tag;
    logic [1:0] resp;
    logic       le;
    logic [2:0] cnt;
    logic       dup;
    logic       unx;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(string nm, int rst_n, int arf, int arid, int arlen,
                             int rv, int rid, int rresp, int rlast, int crdy,
                             int pa, int rr, int cv, int tag, int resp, int le,
                             int cnt, int dup, int unx);
    vec_t t;
    t.name = nm;       t.rst_n = 1'(rst_n);    t.ar_fire = 1'(arf);
    t.ar_id = 4'(arid); t.ar_len = 4'(arlen);  t.rvalid = 1'(rv);
    t.rid = 4'(rid);   t.rresp = 2'(rresp);    t.rlast = 1'(rlast);
    t.cmpl_ready = 1'(crdy);
    t.pa = 1'(pa);     t.rr = 1'(rr);          t.cv = 1'(cv);
    t.tag = 4'(tag);   t.resp = 2'(resp);      t.le = 1'(le);
    t.cnt = 3'(cnt);   t.dup = 1'(dup);        t.unx = 1'(unx);
    return t;
  endfunction

  function automatic vec_t ar(string nm, int id, int len, int pa, int cnt, int dup);
    return v(nm, 1, 1, id, len, 0, 0, 0, 0, 1, pa, 1, 0, 0, 0, 0, cnt, dup, 0);
  endfunction

  function automatic vec_t rb(string nm, int id, int resp, int last, int crdy,
                              int pa, int rr, int cv, int etag, int eresp, int le,
                              int cnt, int unx);
    return v(nm, 1, 0, 0, 0, 1, id, resp, last, crdy, pa, rr, cv, etag, eresp, le, cnt, 0, unx);
  endfunction

  function automatic vec_t idle(string nm, int pa, int cnt);
    return v(nm, 1, 0, 0, 0, 0, 0, 0, 0, 1, pa, 1, 0, 0, 0, 0, cnt, 0, 0);
  endfunction

  task automatic applyStimulus(input vec_t t);
    @(negedge aclk);
    aresetn        = t.rst_n;
    bus.ar_fire    = t.ar_fire;
    bus.ar_id      = t.ar_id;
    bus.ar_len     = t.ar_len;
    bus.rvalid     = t.rvalid;
    bus.rid        = t.rid;
    bus.rresp      = t.rresp;
    bus.rlast      = t.rlast;
    bus.cmpl_ready = t.cmpl_ready;
    @(posedge aclk);
    #1;
  endtask

  task automatic checkOutput(input vec_t t);
    logic ok;
    ok = (pop_allow === t.pa) && (bus.rready === t.rr) && (bus.cmpl_valid === t.cv) &&
         (outstanding_cnt === t.cnt) && (err_dup_id === t.dup) && (err_unexp_r === t.unx);
    // The record payload is only meaningful while valid, or straight out of reset.
    if (t.cv || !t.rst_n)
      ok = ok && (bus.cmpl_tag === t.tag) && (bus.cmpl_resp === t.resp) &&
           (bus.cmpl_len_err === t.le);
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL %s: got pa=%b rr=%b cv=%b tag=%0d resp=%0d le=%b cnt=%0d dup=%b unx=%b, want pa=%b rr=%b cv=%b tag=%0d resp=%0d le=%b cnt=%0d dup=%b unx=%b",
               t.name, pop_allow, bus.rready, bus.cmpl_valid, bus.cmpl_tag, bus.cmpl_resp,
               bus.cmpl_len_err, outstanding_cnt, err_dup_id, err_unexp_r,
               t.pa, t.rr, t.cv, t.tag, t.resp, t.le, t.cnt, t.dup, t.unx);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    aresetn = 1'b0;
    bus.ar_fire = 1'b0; bus.ar_id = '0; bus.ar_len = '0;
    bus.rvalid = 1'b0; bus.rid = '0; bus.rresp = '0; bus.rlast = 1'b0;
    bus.cmpl_ready = 1'b1;

    tbl.push_back(v("reset0", 0, 0,0,0, 0,0,0,0, 1, 1,1,0,0,0,0, 0,0,0));
    tbl.push_back(v("reset1", 0, 0,0,0, 0,0,0,0, 1, 1,1,0,0,0,0, 0,0,0));
    // single 4-beat burst on id 3
    tbl.push_back(ar("s1_ar3", 3, 3, 1, 1, 0));
    tbl.push_back(rb("s1_b1", 3, 0, 0, 1, 1,1,0,0,0,0, 1, 0));
    tbl.push_back(rb("s1_b2", 3, 0, 0, 1, 1,1,0,0,0,0, 1, 0));
    tbl.push_back(rb("s1_b3", 3, 0, 0, 1, 1,1,0,0,0,0, 1, 0));
    tbl.push_back(rb("s1_b4last", 3, 0, 1, 1, 1,1,1,3,0,0, 0, 0));
    tbl.push_back(idle("s1_idle", 1, 0));
    // fill to the limit, then drain
    tbl.push_back(ar("s2_ar0", 0, 0, 1, 1, 0));
    tbl.push_back(ar("s2_ar1", 1, 0, 1, 2, 0));
    tbl.push_back(ar("s2_ar2", 2, 0, 1, 3, 0));
    tbl.push_back(ar("s2_ar3_full", 3, 0, 0, 4, 0));
    tbl.push_back(rb("s2_r2", 2, 0, 1, 1, 1,1,1,2,0,0, 3, 0));
    tbl.push_back(idle("s2_idle", 1, 3));
    tbl.push_back(rb("s2_r0", 0, 0, 1, 1, 1,1,1,0,0,0, 2, 0));
    tbl.push_back(rb("s2_r1", 1, 0, 1, 1, 1,1,1,1,0,0, 1, 0));
    tbl.push_back(rb("s2_r3", 3, 0, 1, 1, 1,1,1,3,0,0, 0, 0));
    tbl.push_back(idle("s2_idle2", 1, 0));
    // response merging
    tbl.push_back(ar("s3_ar5", 5, 1, 1, 1, 0));
    tbl.push_back(rb("s3_b5_okay", 5, 0, 0, 1, 1,1,0,0,0,0, 1, 0));
    tbl.push_back(rb("s3_b5_slverr", 5, 2, 1, 1, 1,1,1,5,2,0, 0, 0));
    tbl.push_back(ar("s3_ar6", 6, 1, 1, 1, 0));
    tbl.push_back(rb("s3_b6_decerr", 6, 3, 0, 1, 1,1,0,0,0,0, 1, 0));
    tbl.push_back(rb("s3_b6_okay", 6, 0, 1, 1, 1,1,1,6,3,0, 0, 0));
    // length errors: short and long bursts
    tbl.push_back(ar("s4_ar4_len3", 4, 3, 1, 1, 0));
    tbl.push_back(rb("s4_b1", 4, 0, 0, 1, 1,1,0,0,0,0, 1, 0));
    tbl.push_back(rb("s4_short_last", 4, 0, 1, 1, 1,1,1,4,0,1, 0, 0));
    tbl.push_back(ar("s4_ar4_len1", 4, 1, 1, 1, 0));
    tbl.push_back(rb("s4_l1", 4, 0, 0, 1, 1,1,0,0,0,0, 1, 0));
    tbl.push_back(rb("s4_l2", 4, 0, 0, 1, 1,1,0,0,0,0, 1, 0));
    tbl.push_back(rb("s4_long_last", 4, 0, 1, 1, 1,1,1,4,0,1, 0, 0));
    // completion backpressure stalls R
    tbl.push_back(ar("s5_ar2", 2, 1, 1, 1, 0));
    tbl.push_back(ar("s5_ar9", 9, 0, 1, 2, 0));
    tbl.push_back(rb("s5_b2", 2, 0, 0, 1, 1,1,0,0,0,0, 2, 0));
    tbl.push_back(rb("s5_b2last_nrdy", 2, 0, 1, 0, 1,0,1,2,0,0, 1, 0));
    tbl.push_back(rb("s5_r9_stall1", 9, 3, 1, 0, 1,0,1,2,0,0, 1, 0));
    tbl.push_back(rb("s5_r9_stall2", 9, 3, 1, 0, 1,0,1,2,0,0, 1, 0));
    tbl.push_back(rb("s5_r9_accept", 9, 3, 1, 1, 1,1,1,9,3,0, 0, 0));
    tbl.push_back(idle("s5_idle", 1, 0));
    // duplicate AR, unexpected R, same-cycle re-arm
    tbl.push_back(ar("s6_ar1", 1, 0, 1, 1, 0));
    tbl.push_back(ar("s6_ar1_dup", 1, 2, 1, 1, 1));
    tbl.push_back(idle("s6_dup_clear", 1, 1));
    tbl.push_back(rb("s6_r1_keeplen", 1, 0, 1, 1, 1,1,1,1,0,0, 0, 0));
    tbl.push_back(rb("s6_r7_unexp", 7, 0, 1, 1, 1,1,0,0,0,0, 0, 1));
    tbl.push_back(idle("s6_unexp_clear", 1, 0));
    tbl.push_back(ar("s6_ar1_again", 1, 0, 1, 1, 0));
    tbl.push_back(v("s6_rearm", 1, 1,1,0, 1,1,1,1, 1, 1,1,1,1,1,0, 1,0,0));
    tbl.push_back(rb("s6_r1_new", 1, 0, 1, 1, 1,1,1,1,0,0, 0, 0));
    tbl.push_back(idle("s6_idle", 1, 0));
    // past the limit the counter keeps tracking
    tbl.push_back(ar("sat_ar0", 0, 0, 1, 1, 0));
    tbl.push_back(ar("sat_ar1", 1, 0, 1, 2, 0));
    tbl.push_back(ar("sat_ar2", 2, 0, 1, 3, 0));
    tbl.push_back(ar("sat_ar3", 3, 0, 0, 4, 0));
    tbl.push_back(ar("sat_ar4_over", 4, 3, 0, 5, 0));
    tbl.push_back(rb("sat_b4", 4, 0, 0, 1, 0,1,0,0,0,0, 5, 0));

    $display("[TB] running %0d table vectors", tbl.size());
    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      checkOutput(tbl[i]);
    end

    begin
      vec_t h;
      // reset lands on the final beat of the id 4 burst: nothing may complete
      h = v("rst_mid_burst", 0, 0,0,0, 1,4,0,1, 1, 1,1,0,0,0,0, 0,0,0);
      applyStimulus(h); checkOutput(h);
      h = idle("rst_release", 1, 0);
      applyStimulus(h); checkOutput(h);
      h = rb("rst_r4_unexp", 4, 0, 1, 1, 1,1,0,0,0,0, 0, 1);
      applyStimulus(h); checkOutput(h);
      h = idle("rst_final", 1, 0);
      applyStimulus(h); checkOutput(h);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb2axi_rd_txn_tracker.md
Name: apb2axi_rd_txn_tracker

Overview:
- Outstanding-read controller between the read request FIFO/read builder and the AXI R channel.
- Throttles FIFO pops so no more than MAX_OUTSTANDING reads are in flight.
- Records each issued AR per ID, counts R beats, checks burst length and merges responses.
- Emits one completion record per burst to the directory/completion logic, and backpressures R when that record cannot be drained.

Parameters:
- AXI_ID_W, 4, ID/tag width; the tag table has 2**AXI_ID_W entries.
- MAX_OUTSTANDING, 4, maximum in-flight read bursts (1..2**AXI_ID_W).
- LEN_W, 4, AR length field width.
- CNT_W, $clog2(MAX_OUTSTANDING+1), outstanding counter width.

Ports:
- aclk, in, 1, clock.
- aresetn, in, 1, synchronous active-low reset.
- pop_allow, out, 1, AND-ed with the builder's pop enable; high when outstanding_cnt < MAX_OUTSTANDING.
- ar_fire, in, 1, arvalid && arready observed on the AR bus.
- ar_id, in, AXI_ID_W, arid of the issued burst.
- ar_len, in, LEN_W, arlen of the issued burst (beats - 1).
- rvalid, in, 1, AXI R valid.
- rid, in, AXI_ID_W, AXI R id.
- rresp, in, 2, AXI R response.
- rlast, in, 1, AXI R last.
- rready, out, 1, AXI R ready driven by this block.
- cmpl_valid, out, 1, completion record valid.
- cmpl_ready, in, 1, consumer accepts the completion record.
- cmpl_tag, out, AXI_ID_W, completed ID.
- cmpl_resp, out, 2, merged response of the burst.
- cmpl_len_err, out, 1, beat count differed from ar_len+1.
- outstanding_cnt, out, CNT_W, in-flight bursts.
- err_dup_id, out, 1, one-cycle pulse: AR issued on an ID already in flight.
- err_unexp_r, out, 1, one-cycle pulse: R beat on an ID not in flight.

Behaviour:
- Reset (aresetn=0 at posedge):
  - All table entries invalid; outstanding_cnt=0; cmpl_valid=0; cmpl_tag/resp/len_err=0; err pulses=0.
  - pop_allow=1 and rready=1 follow combinationally from reset state.
  - Reset mid-burst drops all tracking; no completion is emitted.
- Table entry per ID: vld, exp_len[LEN_W], beat_cnt[LEN_W+1], resp_acc[2], len_err.
- AR issue (ar_fire):
  - If entry[ar_id].vld=0: next cycle vld=1, exp_len=ar_len, beat_cnt=0, resp_acc=OKAY, len_err=0, outstanding_cnt+1.
  - If entry[ar_id].vld=1: err_dup_id pulses the next cycle; the entry is not overwritten and the count is unchanged.
- pop_allow: combinational, outstanding_cnt < MAX_OUTSTANDING.
- rready: combinational, !cmpl_valid || cmpl_ready, so R stalls only while an undrained completion is held.
- Beat accepted when rvalid && rready:
  - rid not valid: err_unexp_r pulses next cycle, beat dropped, no state change.
  - Otherwise resp_acc = max(resp_acc, rresp), numeric, so DECERR > SLVERR > EXOKAY > OKAY, and beat_cnt+1.
  - A non-last beat when beat_cnt == exp_len+1 (too many beats) sets len_err.
  - On rlast, len_err |= (beat_cnt+1 != exp_len+1).
  - On rlast, next cycle: cmpl_valid=1 with tag/merged resp/len_err, entry vld=0, outstanding_cnt-1.
- Completion register: single entry.
  - Held stable while cmpl_valid && !cmpl_ready.
  - Cleared when cmpl_ready, unless reloaded by an rlast in the same cycle. Back-to-back completions on consecutive cycles are allowed when cmpl_ready=1.
- Latency: rlast beat → cmpl_valid is 1 cycle; ar_fire → pop_allow update is 1 cycle.
- Simultaneous ar_fire and rlast completion in the same cycle:
  - outstanding_cnt unchanged.
  - If ar_id equals the completing rid, the new AR is accepted; completion takes priority on the old contents, then the new entry is written, with no dup error.
- Counter never wraps: at MAX_OUTSTANDING, pop_allow=0. An ar_fire arriving anyway is still tracked if the ID is free, with the counter saturating at 2**CNT_W-1.
- R interleaving across IDs is supported; each ID is tracked independently.

Test Plan:
- Reset, single AR id=3 len=3, 4 R beats OKAY with rlast on the 4th → one cmpl_valid, tag=3, resp=0, len_err=0; outstanding 0→1→0.
- 4 ARs (ids 0..3) with no R → pop_allow=0 after the 4th; return id2 burst → pop_allow=1 one cycle after its completion; outstanding_cnt=3.
- id=5 len=1 with beats rresp=OKAY then SLVERR(last) → cmpl_resp=2; a separate burst with DECERR on the 1st beat → resp=3.
- len=3 with rlast on the 2nd beat → cmpl_len_err=1; len=1 with 3 beats, rlast on the 3rd → len_err=1.
- cmpl_ready=0 while rlast completes → cmpl_valid held, rready=0, R beats stall; raise cmpl_ready → handshake, next beat accepted.
- AR on an in-flight id → err_dup_id pulse; R on idle id 7 → err_unexp_r pulse; simultaneous rlast(id1) + ar_fire(id1) → completion emitted, id1 re-armed, count unchanged; aresetn low mid-burst → all state cleared, no completion.
